// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - handshake and data bundle for the sequential divider
//
// Purpose : groups the request (Start/Signed/Dividend/Divisor) and result
//           (Quotient/Remainder/Busy/Done/DivByZero/Overflow) signals.
// Modports: master - requester side, drives the request, observes the result
//           slave  - divider side, samples the request, drives the result
interface seq_divider_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic             Signed;
   logic [WIDTH-1:0] Dividend;
   logic [WIDTH-1:0] Divisor;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic             Busy;
   logic             Done;
   logic             DivByZero;
   logic             Overflow;

   modport master (
      output Start, Signed, Dividend, Divisor,
      input  Quotient, Remainder, Busy, Done, DivByZero, Overflow
   );

   modport slave (
      input  Start, Signed, Dividend, Divisor,
      output Quotient, Remainder, Busy, Done, DivByZero, Overflow
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring sequential divider, one quotient bit per clock
//
// Purpose : WIDTH-bit divider (IDLE/RUN/DONE FSM). Done pulses WIDTH+1 edges
//           after the Start-sampling edge, or 1 edge for a zero divisor.
// Ports   : Clk      - clock, rising edge
//           nRst     - asynchronous active-low reset
//           bus      - seq_divider_if.slave (request in, result out)
// Macro   : SEQ_DIVIDER_SIGNED_EN - when defined, Signed selects two's-complement
//           operation; when undefined all operations are unsigned and
//           Overflow stays 0.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input logic          Clk,
   input logic          nRst,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   rem_q, rem_d;      // partial remainder magnitude
   logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH:0]   dvs_q, dvs_d;      // divisor magnitude
   logic             neg_q_q, neg_q_d;  // negate quotient at the end
   logic             neg_r_q, neg_r_d;  // negate remainder at the end
   logic             ovf_p_q, ovf_p_d;  // MIN/-1 seen at load
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   // Operand conditioning at load time
   logic             signed_op, dd_neg, ds_neg, ovf_in;
   logic [WIDTH-1:0] dd_mag, ds_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
   assign signed_op = bus.Signed;
   assign ovf_in    = signed_op && (bus.Dividend == MIN_VAL) && (bus.Divisor == '1);
`else
   assign signed_op = 1'b0;
   assign ovf_in    = 1'b0;
`endif

   assign dd_neg = signed_op & bus.Dividend[WIDTH-1];
   assign ds_neg = signed_op & bus.Divisor[WIDTH-1];
   // -MIN wraps back to MIN, which read as unsigned is exactly |MIN|
   assign dd_mag = dd_neg ? -bus.Dividend : bus.Dividend;
   assign ds_mag = ds_neg ? -bus.Divisor  : bus.Divisor;

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   // The extra top bit of the difference is the borrow.
   logic [WIDTH+1:0] sh_w, diff_w;
   logic             qbit;
   logic [WIDTH:0]   rem_n;
   logic [WIDTH-1:0] q_n, q_fin, r_fin;

   assign sh_w   = {rem_q, dvd_q[WIDTH-1]};
   assign diff_w = sh_w - {1'b0, dvs_q};
   assign qbit   = ~diff_w[WIDTH+1];
   assign rem_n  = qbit ? diff_w[WIDTH:0] : sh_w[WIDTH:0];
   assign q_n    = {dvd_q[WIDTH-2:0], qbit};
   assign q_fin  = neg_q_q ? -q_n : q_n;
   assign r_fin  = neg_r_q ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         ovf_p_q <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
         ovf_p_q <= ovf_p_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      ovf_p_d = ovf_p_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.Start) begin
               if (bus.Divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  remo_d  = bus.Dividend;
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = RUN;
                  cnt_d   = CW'(WIDTH);
                  rem_d   = '0;
                  dvd_d   = dd_mag;
                  dvs_d   = {1'b0, ds_mag};
                  neg_q_d = dd_neg ^ ds_neg;
                  neg_r_d = dd_neg;
                  ovf_p_d = ovf_in;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q - 1'b1;
            rem_d = rem_n;
            dvd_d = q_n;
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               quot_d  = q_fin;
               remo_d  = r_fin;
               dbz_d   = 1'b0;
               ovf_d   = ovf_p_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.Quotient  = quot_q;
   assign bus.Remainder = remo_q;
   assign bus.Busy      = (state_q == RUN);
   assign bus.Done      = (state_q == DONE);
   assign bus.DivByZero = dbz_q;
   assign bus.Overflow  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (WIDTH=8)
module tb_seq_divider;

   localparam int W = 8;

   logic Clk;
   logic nRst;
   int   n_tests;
   int   n_fail;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .Clk  (Clk),
      .nRst (nRst),
      .bus  (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Drive a request at a falling edge, release Start after the sampling edge,
   // then count rising edges until Done (bounded).
   task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
      @(negedge Clk);
      bus.Start    = 1'b1;
      bus.Signed   = sgn;
      bus.Dividend = a;
      bus.Divisor  = b;
      @(posedge Clk);
      #1 bus.Start = 1'b0;
      lat = 1;
      if (bus.Done !== 1'b1) begin
         for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1 lat++;
            if (bus.Done === 1'b1) break;
         end
         if (bus.Done !== 1'b1) lat = -1;
      end
   endtask

   task automatic test_reset();
      nRst = 1'b0;
      bus.Start = 1'b0; bus.Signed = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
      #2;
      n_tests++;
      if ({bus.Quotient, bus.Remainder, bus.Busy, bus.Done, bus.DivByZero, bus.Overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
                  bus.Quotient, bus.Remainder, bus.Busy, bus.Done, bus.DivByZero, bus.Overflow);
      end
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      nRst = 1'b1;
   endtask

   task automatic test_unsigned();
      int lat;
      logic [W-1:0] a [3] = '{8'd100, 8'd255, 8'd7};
      logic [W-1:0] b [3] = '{8'd7,   8'd1,   8'd200};
      logic [W-1:0] q [3] = '{8'd14,  8'd255, 8'd0};
      logic [W-1:0] r [3] = '{8'd2,   8'd0,   8'd7};
      for (int k = 0; k < 3; k++) begin
         run_op(1'b0, a[k], b[k], lat);
         n_tests++;
         if (lat !== 9 || bus.Quotient !== q[k] || bus.Remainder !== r[k] ||
             bus.DivByZero !== 1'b0 || bus.Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL unsigned_%0d: got lat=%0d q=%h r=%h dbz=%b ovf=%b, want lat=9 q=%h r=%h flags 0",
                     k, lat, bus.Quotient, bus.Remainder, bus.DivByZero, bus.Overflow, q[k], r[k]);
         end
      end
   endtask

   task automatic test_signed();
      int lat;
      logic [W-1:0] eq0, er0, eq1, er1;
`ifdef SEQ_DIVIDER_SIGNED_EN
      eq0 = 8'hF2; er0 = 8'hFE; eq1 = 8'hF2; er1 = 8'h02;
`else
      eq0 = 8'h16; er0 = 8'h02; eq1 = 8'h00; er1 = 8'h64;
`endif
      run_op(1'b1, 8'h9C, 8'd7, lat);
      n_tests++;
      if (lat !== 9 || bus.Quotient !== eq0 || bus.Remainder !== er0) begin
         n_fail++;
         $display("FAIL signed_neg_dividend: got lat=%0d q=%h r=%h, want lat=9 q=%h r=%h",
                  lat, bus.Quotient, bus.Remainder, eq0, er0);
      end
      run_op(1'b1, 8'd100, 8'hF9, lat);
      n_tests++;
      if (lat !== 9 || bus.Quotient !== eq1 || bus.Remainder !== er1) begin
         n_fail++;
         $display("FAIL signed_neg_divisor: got lat=%0d q=%h r=%h, want lat=9 q=%h r=%h",
                  lat, bus.Quotient, bus.Remainder, eq1, er1);
      end
   endtask

   task automatic test_div_by_zero();
      int lat;
      run_op(1'b0, 8'd5, 8'd0, lat);
      n_tests++;
      if (lat !== 1 || bus.Quotient !== 8'hFF || bus.Remainder !== 8'h05 ||
          bus.DivByZero !== 1'b1 || bus.Overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL div_by_zero: got lat=%0d q=%h r=%h dbz=%b ovf=%b, want lat=1 q=ff r=05 dbz=1 ovf=0",
                  lat, bus.Quotient, bus.Remainder, bus.DivByZero, bus.Overflow);
      end
      @(posedge Clk);
      #1;
      n_tests++;
      if (bus.Done !== 1'b0 || bus.DivByZero !== 1'b1 || bus.Quotient !== 8'hFF) begin
         n_fail++;
         $display("FAIL done_single_cycle_hold: got done=%b dbz=%b q=%h, want done=0 dbz=1 q=ff",
                  bus.Done, bus.DivByZero, bus.Quotient);
      end
   endtask

   task automatic test_overflow();
      int lat;
      logic [W-1:0] eq, er;
      logic         eo;
`ifdef SEQ_DIVIDER_SIGNED_EN
      eq = 8'h80; er = 8'h00; eo = 1'b1;
`else
      eq = 8'h00; er = 8'h80; eo = 1'b0;
`endif
      run_op(1'b1, 8'h80, 8'hFF, lat);
      n_tests++;
      if (lat !== 9 || bus.Quotient !== eq || bus.Remainder !== er ||
          bus.Overflow !== eo || bus.DivByZero !== 1'b0) begin
         n_fail++;
         $display("FAIL signed_min_by_neg1: got lat=%0d q=%h r=%h ovf=%b dbz=%b, want lat=9 q=%h r=%h ovf=%b dbz=0",
                  lat, bus.Quotient, bus.Remainder, bus.Overflow, bus.DivByZero, eq, er, eo);
      end
      run_op(1'b0, 8'h80, 8'hFF, lat);
      n_tests++;
      if (lat !== 9 || bus.Quotient !== 8'h00 || bus.Remainder !== 8'h80 || bus.Overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL unsigned_80_by_ff: got lat=%0d q=%h r=%h ovf=%b, want lat=9 q=00 r=80 ovf=0",
                  lat, bus.Quotient, bus.Remainder, bus.Overflow);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      @(negedge Clk);
      bus.Start = 1'b1; bus.Signed = 1'b0; bus.Dividend = 8'd100; bus.Divisor = 8'd7;
      @(posedge Clk);
      #1 bus.Start = 1'b0;
      n_tests++;
      if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_start: got busy=%b done=%b, want busy=1 done=0", bus.Busy, bus.Done);
      end
      lat = 1;
      repeat (2) begin
         @(posedge Clk);
         #1 lat++;
      end
      bus.Start = 1'b1; bus.Signed = 1'b1; bus.Dividend = 8'd200; bus.Divisor = 8'd10;
      @(posedge Clk);
      #1 lat++;
      bus.Start = 1'b0; bus.Dividend = 8'd3; bus.Divisor = 8'd0;
      for (int i = 0; i < 40 && bus.Done !== 1'b1; i++) begin
         @(posedge Clk);
         #1 lat++;
      end
      n_tests++;
      if (bus.Done !== 1'b1 || lat !== 9 || bus.Quotient !== 8'd14 || bus.Remainder !== 8'd2) begin
         n_fail++;
         $display("FAIL start_ignored_when_busy: got done=%b lat=%0d q=%h r=%h, want done=1 lat=9 q=0e r=02",
                  bus.Done, lat, bus.Quotient, bus.Remainder);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(1'b0, 8'd50, 8'd5, lat);
      n_tests++;
      if (lat !== 9 || bus.Quotient !== 8'd10 || bus.Remainder !== 8'd0) begin
         n_fail++;
         $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=9 q=0a r=00", lat, bus.Quotient, bus.Remainder);
      end
      // Start held while in DONE: the next edge must launch the second op
      bus.Start = 1'b1; bus.Dividend = 8'd77; bus.Divisor = 8'd8;
      @(posedge Clk);
      #1 bus.Start = 1'b0;
      n_tests++;
      if (bus.Busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_launch: got busy=%b, want busy=1", bus.Busy);
      end
      lat = 1;
      for (int i = 0; i < 40 && bus.Done !== 1'b1; i++) begin
         @(posedge Clk);
         #1 lat++;
      end
      n_tests++;
      if (bus.Done !== 1'b1 || lat !== 9 || bus.Quotient !== 8'd9 || bus.Remainder !== 8'd5) begin
         n_fail++;
         $display("FAIL b2b_second: got done=%b lat=%0d q=%h r=%h, want done=1 lat=9 q=09 r=05",
                  bus.Done, lat, bus.Quotient, bus.Remainder);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int seen_done;
      @(negedge Clk);
      bus.Start = 1'b1; bus.Signed = 1'b0; bus.Dividend = 8'd100; bus.Divisor = 8'd7;
      @(posedge Clk);
      #1 bus.Start = 1'b0;
      repeat (4) @(posedge Clk);
      #2 nRst = 1'b0;
      #1;
      n_tests++;
      if ({bus.Quotient, bus.Remainder, bus.Busy, bus.Done, bus.DivByZero, bus.Overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
                  bus.Quotient, bus.Remainder, bus.Busy, bus.Done, bus.DivByZero, bus.Overflow);
      end
      @(negedge Clk);
      nRst = 1'b1;
      seen_done = 0;
      repeat (12) begin
         @(posedge Clk);
         #1 if (bus.Done === 1'b1 || bus.Busy === 1'b1) seen_done++;
      end
      n_tests++;
      if (seen_done !== 0) begin
         n_fail++;
         $display("FAIL reset_abort_no_done: got %0d busy/done cycles, want 0", seen_done);
      end
      run_op(1'b0, 8'd200, 8'd10, lat);
      n_tests++;
      if (lat !== 9 || bus.Quotient !== 8'd20 || bus.Remainder !== 8'd0) begin
         n_fail++;
         $display("FAIL after_reset_op: got lat=%0d q=%h r=%h, want lat=9 q=14 r=00", lat, bus.Quotient, bus.Remainder);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_by_zero();
      test_overflow();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand and result width in bits; legal range 2..64.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 nRst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Start  input  1  SHALL request a division; it is sampled only while Busy=0.
REQ-005 Signed  input  1  SHALL select two's-complement (1) or unsigned (0) operation; it is sampled with Start.
REQ-006 Dividend  input  WIDTH  SHALL be the numerator; it is sampled with Start.
REQ-007 Divisor  input  WIDTH  SHALL be the denominator; it is sampled with Start.
REQ-008 Quotient  output  WIDTH  SHALL be the registered quotient.
REQ-009 Remainder  output  WIDTH  SHALL be the registered remainder.
REQ-010 Busy  output  1  SHALL be high while an operation is in progress.
REQ-011 Done  output  1  SHALL be a single-cycle pulse marking valid new results.
REQ-012 DivByZero  output  1  SHALL be high when the last result came from Divisor=0.
REQ-013 Overflow  output  1  SHALL be high when the last result came from signed MIN/-1.

Function
REQ-014 The state machine SHALL have states IDLE, RUN and DONE; Busy=1 exactly in RUN.
REQ-015 IDLE or DONE with Start=1 and Divisor!=0 SHALL load the operands and go to RUN, with the iteration counter set to WIDTH.
REQ-016 IDLE or DONE with Start=1 and Divisor=0 SHALL go directly to DONE, giving Quotient=all ones, Remainder=Dividend, DivByZero=1, Overflow=0.
REQ-017 RUN SHALL perform one restoring-division step on operand magnitudes per cycle: shift the partial remainder, trial-subtract the divisor, and keep the difference with quotient bit 1 if it is non-negative.
REQ-018 RUN SHALL decrement the counter each cycle and go to DONE after the step in which the counter reaches 0.
REQ-019 Latency: Done SHALL go high exactly WIDTH+1 clock edges after the edge that sampled Start (1 edge for divide-by-zero).
REQ-020 DONE SHALL last one cycle with Done=1, then go to IDLE unless Start=1, which begins a new operation back-to-back.
REQ-021 Quotient, Remainder, DivByZero and Overflow SHALL update only on entry to DONE and hold until the next entry.
REQ-022 Intermediate iteration values SHALL never appear on the outputs.
REQ-023 Signed mode SHALL truncate toward zero; the Quotient sign SHALL be Dividend sign XOR Divisor sign, and the Remainder sign SHALL follow the Dividend (|Remainder| < |Divisor|).
REQ-024 Signed Dividend=MIN with Divisor=-1 SHALL give Quotient=MIN, Remainder=0, Overflow=1 in normal RUN latency.
REQ-025 Start while Busy=1 SHALL be ignored; input changes during RUN SHALL not affect the result.
REQ-026 Internal magnitude datapath SHALL be WIDTH+1 bits so that |MIN| is represented without loss.

Reset
REQ-027 nRst low SHALL immediately force IDLE and Quotient=0, Remainder=0, Busy=0, Done=0, DivByZero=0, Overflow=0, counter=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no Done pulse; the first Start after release SHALL begin a fresh operation.

Configuration
REQ-029 Macro SEQ_DIVIDER_SIGNED_EN defined SHALL compile in the signed path (REQ-023, REQ-024) controlled by Signed.
REQ-030 Macro SEQ_DIVIDER_SIGNED_EN undefined SHALL remove the signed logic: Signed is ignored, all operations are unsigned, and Overflow is tied to 0.

Verification
REQ-031 WIDTH=8, unsigned 100/7 -> Quotient=14, Remainder=2, Done 9 edges after Start, flags 0.
REQ-032 WIDTH=8, signed -100/7 -> Quotient=0xF2 (-14), Remainder=0xFE (-2); signed 100/-7 -> Quotient=0xF2, Remainder=0x02.
REQ-033 5/0 -> Done 1 edge after Start, Quotient=0xFF, Remainder=0x05, DivByZero=1.
REQ-034 Signed 0x80/0xFF -> Quotient=0x80, Remainder=0, Overflow=1; the same operands unsigned -> Quotient=0, Remainder=0x80, Overflow=0.
REQ-035 Start pulsed with new operands during RUN -> ignored, and the original result is unchanged; Start held high in DONE -> next operation starts back-to-back.
REQ-036 nRst pulsed at RUN cycle 4 -> all outputs 0 at once, no Done; a following 200/10 -> Quotient=20, Remainder=0.
